// File: rtl/my_cpu_pkg.sv
// Shared types and Hack instruction field positions for the my_cpu_ctrl slice.
package my_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MWRITE = 2'd2
  } state_t;

  localparam int BIT_CINSTR = 15;
  localparam int BIT_A      = 12;
  localparam int CTRL_HI    = 11;
  localparam int CTRL_LO    = 6;
  localparam int DEST_A     = 5;
  localparam int DEST_D     = 4;
  localparam int DEST_M     = 3;
  localparam int J_LT       = 2;
  localparam int J_EQ       = 1;
  localparam int J_GT       = 0;

  function automatic logic [5:0] ctrl_field(input logic [15:0] ir);
    return ir[CTRL_HI:CTRL_LO];
  endfunction

endpackage

// File: rtl/my_jump_unit.sv
// Gate-level jump decision: taken = (lt & ng) | (eq & zr) | (gt & ~ng & ~zr).
module my_not (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module my_and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module my_or (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module my_jump_unit (
  input  logic [2:0] jmp_bits,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);
  logic not_ng_s, not_zr_s, pos_s;
  logic lt_hit_s, eq_hit_s, gt_hit_s, lt_eq_s;

  my_not u_not_ng (.a(ng), .y(not_ng_s));
  my_not u_not_zr (.a(zr), .y(not_zr_s));
  my_and u_pos    (.a(not_ng_s), .b(not_zr_s), .y(pos_s));
  my_and u_lt     (.a(jmp_bits[2]), .b(ng), .y(lt_hit_s));
  my_and u_eq     (.a(jmp_bits[1]), .b(zr), .y(eq_hit_s));
  my_and u_gt     (.a(jmp_bits[0]), .b(pos_s), .y(gt_hit_s));
  my_or  u_or0    (.a(lt_hit_s), .b(eq_hit_s), .y(lt_eq_s));
  my_or  u_or1    (.a(lt_eq_s), .b(gt_hit_s), .y(taken));
endmodule

// File: rtl/my_cpu_ctrl.sv
// Hack CPU control shell: FETCH/EXEC/MWRITE sequencing, A/D/PC registers, ALU drive.
// Optional retired-instruction counter port enabled by MY_CPU_CTRL_RETIRE_CNT_EN.
module my_cpu_ctrl
  import my_cpu_pkg::*;
#(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     in_m,
  output logic [PC_W-1:0] address_m,
  output logic [15:0]     out_m,
  output logic            write_m,
  input  logic            mem_wr_ready,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng
`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
  , output logic [15:0]   retired
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_r, state_nxt_s;
  logic [15:0]     a_r, d_r, ir_r, out_m_r;
  logic [PC_W-1:0] pc_r, addr_r;
  logic            taken_s, exec_c_s, retire_s;

  my_jump_unit u_jump (
    .jmp_bits (ir_r[J_LT:J_GT]),
    .zr       (alu_zr),
    .ng       (alu_ng),
    .taken    (taken_s)
  );

  assign exec_c_s    = (state_r == EXEC) && ir_r[BIT_CINSTR];
  assign instr_ready = (state_r == FETCH);
  assign write_m     = (state_r == MWRITE);
  assign out_m       = out_m_r;
  assign pc          = pc_r;
  // The write address is frozen while MWRITE waits, even if A was just rewritten.
  assign address_m   = (state_r == MWRITE) ? addr_r : a_r[PC_W-1:0];
  assign retire_s    = ((state_r == EXEC) && (state_nxt_s == FETCH)) ||
                       ((state_r == MWRITE) && mem_wr_ready);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (instr_valid) state_nxt_s = EXEC;
        else             state_nxt_s = FETCH;
      end
      EXEC: begin
        if (ir_r[BIT_CINSTR] && ir_r[DEST_M]) state_nxt_s = MWRITE;
        else                                  state_nxt_s = FETCH;
      end
      MWRITE: begin
        if (mem_wr_ready) state_nxt_s = FETCH;
        else              state_nxt_s = MWRITE;
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  // ALU operand and control drive, zero outside a C-instruction EXEC
  always_comb begin
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000000;
    alu_x = 16'h0000;
    alu_y = 16'h0000;
    if (exec_c_s) begin
      {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl_field(ir_r);
      alu_x = d_r;
      if (ir_r[BIT_A]) alu_y = in_m;
      else             alu_y = a_r;
    end else begin
      alu_x = 16'h0000;
      alu_y = 16'h0000;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= FETCH;
    else        state_r <= state_nxt_s;
  end

  // Architectural registers; every EXEC read uses pre-update values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= 16'h0000;
      d_r     <= 16'h0000;
      ir_r    <= 16'h0000;
      pc_r    <= RESET_PC;
      out_m_r <= 16'h0000;
      addr_r  <= '0;
    end else begin
      case (state_r)
        FETCH: begin
          if (instr_valid) ir_r <= instr;
        end
        EXEC: begin
          if (!ir_r[BIT_CINSTR]) begin
            a_r  <= ir_r;
            pc_r <= pc_r + PC_ONE;
          end else begin
            if (ir_r[DEST_A]) a_r <= alu_out;
            if (ir_r[DEST_D]) d_r <= alu_out;
            if (ir_r[DEST_M]) begin
              out_m_r <= alu_out;
              addr_r  <= a_r[PC_W-1:0];
            end
            pc_r <= taken_s ? a_r[PC_W-1:0] : (pc_r + PC_ONE);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_r;
  assign retired = retired_r;

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired_r <= 16'h0000;
    else if (retire_s) retired_r <= retired_r + 16'h0001;
    else               retired_r <= retired_r;
  end
`else
  logic unused_retire_s;
  assign unused_retire_s = retire_s;
`endif

endmodule

// File: tb/tb_my_cpu_ctrl.sv
// Table-driven bench for my_cpu_ctrl; the bench plays ROM, RAM and ALU.
module tb_my_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] in_m = 16'h0000;
  logic [14:0] address_m;
  logic [15:0] out_m;
  logic        write_m;
  logic        mem_wr_ready = 1'b0;
  logic [15:0] alu_x, alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out = 16'h0000;
  logic        alu_zr = 1'b0;
  logic        alu_ng = 1'b0;
`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  my_cpu_ctrl #(.PC_W(15), .RESET_PC(15'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .in_m(in_m), .address_m(address_m),
    .out_m(out_m), .write_m(write_m), .mem_wr_ready(mem_wr_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx),
    .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] in_m;
    logic [15:0] alu_out;
    logic        zr;
    logic        ng;
    int          stall;
    logic        wr;
    logic [5:0]  exp_ctrl;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
    logic [14:0] exp_addr;
    logic [15:0] exp_out;
    logic [14:0] exp_pc;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;

  function automatic logic [5:0] ctrl_now();
    return {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one instruction through FETCH/EXEC(/MWRITE); called just after a negedge in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d ready_fetch", idx), {31'b0, instr_ready}, 32'd1);
    instr = v.instr; instr_valid = 1'b1;
    in_m = v.in_m; alu_out = v.alu_out; alu_zr = v.zr; alu_ng = v.ng;
    @(negedge clk);
    instr_valid = 1'b0;
    chk($sformatf("v%0d ready_exec", idx), {31'b0, instr_ready}, 32'd0);
    chk($sformatf("v%0d ctrl", idx), {26'b0, ctrl_now()}, {26'b0, v.exp_ctrl});
    chk($sformatf("v%0d alu_x", idx), {16'b0, alu_x}, {16'b0, v.exp_x});
    chk($sformatf("v%0d alu_y", idx), {16'b0, alu_y}, {16'b0, v.exp_y});
    @(negedge clk);
    if (v.wr) begin
      for (int i = 0; i <= v.stall; i++) begin
        chk($sformatf("v%0d write_m", idx), {31'b0, write_m}, 32'd1);
        chk($sformatf("v%0d address_m", idx), {17'b0, address_m}, {17'b0, v.exp_addr});
        chk($sformatf("v%0d out_m", idx), {16'b0, out_m}, {16'b0, v.exp_out});
        mem_wr_ready = (i == v.stall);
        @(negedge clk);
      end
      mem_wr_ready = 1'b0;
    end
    chk($sformatf("v%0d write_m_low", idx), {31'b0, write_m}, 32'd0);
    chk($sformatf("v%0d pc", idx), {17'b0, pc}, {17'b0, v.exp_pc});
    exp_ret++;
`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
    chk($sformatf("v%0d retired", idx), {16'b0, retired}, exp_ret);
`endif
  endtask

  function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] im,
                              input logic [15:0] ao, input logic z, input logic n,
                              input int st, input logic w, input logic [5:0] c,
                              input logic [15:0] x, input logic [15:0] y,
                              input logic [14:0] ad, input logic [15:0] o,
                              input logic [14:0] p);
    vec_t v;
    v.instr = ins; v.in_m = im; v.alu_out = ao; v.zr = z; v.ng = n;
    v.stall = st; v.wr = w; v.exp_ctrl = c; v.exp_x = x; v.exp_y = y;
    v.exp_addr = ad; v.exp_out = o; v.exp_pc = p;
    return v;
  endfunction

  initial begin
    //               instr      in_m       alu_out    zr    ng    st wr    ctrl       x          y          addr       out        pc
    vq.push_back(mk(16'h0007, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0001));
    vq.push_back(mk(16'hEC10, 16'hBEEF, 16'h0007, 1'b0, 1'b0, 0, 1'b0, 6'b110000, 16'h0000, 16'h0007, 15'h0000, 16'h0000, 15'h0002));
    vq.push_back(mk(16'h0005, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0003));
    vq.push_back(mk(16'hEC10, 16'hBEEF, 16'h0005, 1'b0, 1'b0, 0, 1'b0, 6'b110000, 16'h0007, 16'h0005, 15'h0000, 16'h0000, 15'h0004));
    vq.push_back(mk(16'h0064, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0005));
    vq.push_back(mk(16'hE308, 16'hBEEF, 16'h0005, 1'b0, 1'b0, 3, 1'b1, 6'b001100, 16'h0005, 16'h0064, 15'h0064, 16'h0005, 15'h0006));
    vq.push_back(mk(16'h002A, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0007));
    vq.push_back(mk(16'hE302, 16'hBEEF, 16'h0005, 1'b1, 1'b0, 0, 1'b0, 6'b001100, 16'h0005, 16'h002A, 15'h0000, 16'h0000, 15'h002A));
    vq.push_back(mk(16'h002A, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h002B));
    vq.push_back(mk(16'hE302, 16'hBEEF, 16'h0005, 1'b0, 1'b0, 0, 1'b0, 6'b001100, 16'h0005, 16'h002A, 15'h0000, 16'h0000, 15'h002C));
    vq.push_back(mk(16'h0064, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h002D));
    vq.push_back(mk(16'hE304, 16'hBEEF, 16'hFFFF, 1'b0, 1'b1, 0, 1'b0, 6'b001100, 16'h0005, 16'h0064, 15'h0000, 16'h0000, 15'h0064));
    vq.push_back(mk(16'h0032, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0065));
    vq.push_back(mk(16'hE301, 16'hBEEF, 16'hFFFB, 1'b0, 1'b1, 0, 1'b0, 6'b001100, 16'h0005, 16'h0032, 15'h0000, 16'h0000, 15'h0066));
    vq.push_back(mk(16'hE307, 16'hBEEF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 6'b001100, 16'h0005, 16'h0032, 15'h0000, 16'h0000, 15'h0032));
    vq.push_back(mk(16'hFC38, 16'h0009, 16'h0009, 1'b0, 1'b0, 0, 1'b1, 6'b110000, 16'h0005, 16'h0009, 15'h0032, 16'h0009, 15'h0033));
    vq.push_back(mk(16'h8C10, 16'hBEEF, 16'h0009, 1'b0, 1'b0, 0, 1'b0, 6'b110000, 16'h0009, 16'h0009, 15'h0000, 16'h0000, 15'h0034));
    vq.push_back(mk(16'hE308, 16'hBEEF, 16'h0009, 1'b0, 1'b0, 1, 1'b1, 6'b001100, 16'h0009, 16'h0009, 15'h0009, 16'h0009, 15'h0035));
    vq.push_back(mk(16'h7FFF, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0036));
    vq.push_back(mk(16'hEA87, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 6'b101010, 16'h0009, 16'h7FFF, 15'h0000, 16'h0000, 15'h7FFF));
    vq.push_back(mk(16'h0001, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000, 16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0000));
    vq.push_back(mk(16'hEC2F, 16'hBEEF, 16'h0077, 1'b0, 1'b0, 0, 1'b1, 6'b110000, 16'h0009, 16'h0001, 15'h0001, 16'h0077, 15'h0001));
    vq.push_back(mk(16'hEC10, 16'hBEEF, 16'h0077, 1'b0, 1'b0, 0, 1'b0, 6'b110000, 16'h0009, 16'h0077, 15'h0000, 16'h0000, 15'h0002));

    // Reset state, then idle with no valid instruction
    #3;
    chk("rst pc", {17'b0, pc}, 32'd0);
    chk("rst ready", {31'b0, instr_ready}, 32'd1);
    chk("rst write_m", {31'b0, write_m}, 32'd0);
    chk("rst ctrl", {26'b0, ctrl_now()}, 32'd0);
    chk("rst alu_x", {16'b0, alu_x}, 32'd0);
    chk("rst alu_y", {16'b0, alu_y}, 32'd0);
    chk("rst out_m", {16'b0, out_m}, 32'd0);
`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
    chk("rst retired", {16'b0, retired}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle pc", {17'b0, pc}, 32'd0);
      chk("idle ready", {31'b0, instr_ready}, 32'd1);
      chk("idle write_m", {31'b0, write_m}, 32'd0);
    end

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Reset in the middle of a stalled memory write
    run_vec(mk(16'h0064, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000,
               16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0003), 100);
    instr = 16'hE308; instr_valid = 1'b1; alu_out = 16'h0055;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid write_m", {31'b0, write_m}, 32'd1);
    chk("mid address_m", {17'b0, address_m}, 32'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("abort write_m", {31'b0, write_m}, 32'd0);
    chk("abort ready", {31'b0, instr_ready}, 32'd1);
    chk("abort pc", {17'b0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
`ifdef MY_CPU_CTRL_RETIRE_CNT_EN
    chk("abort retired", {16'b0, retired}, 32'd0);
`endif
    run_vec(mk(16'h0003, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000,
               16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0001), 101);
    run_vec(mk(16'h0004, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 6'b000000,
               16'h0000, 16'h0000, 15'h0000, 16'h0000, 15'h0002), 102);
    run_vec(mk(16'hEC10, 16'hBEEF, 16'h0004, 1'b0, 1'b0, 0, 1'b0, 6'b110000,
               16'h0000, 16'h0004, 15'h0000, 16'h0000, 15'h0003), 103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
